mac_acc: RTL and testbench

Accumulation stage directly downstream of the 16x16 multiplier in the integer MAC datapath. It consumes one 32-bit unsigned product per accepted beat and sums a programmed number of products into a wide saturating accumulator. It then presents the dot-product result on a valid/ready output port. Supports int16 mode (full 32-bit product) and int8 mode (product masked to bits [15:0]).

---
 rtl/mac_acc_pkg.sv | 14 +
 rtl/mac_acc_if.sv | 27 ++
 rtl/mac_acc_cla_nbit.sv | 26 ++
 rtl/mac_acc.sv | 97 +++++++++
 tb/tb_mac_acc.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mac_acc_pkg.sv
// Shared definitions for the MAC accumulation stage: FSM encoding and default widths.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned ACC_W_DEF   = 40;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned INT8_PROD_W = 16;

endpackage

// File: rtl/mac_acc_if.sv
// Job control, product input and result output handshakes of the accumulation stage.
interface mac_acc_if import mac_pkg::*; #(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             int8_mode;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             busy;

  modport master (
    output start, len, int8_mode, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, busy
  );

  modport slave (
    input  start, len, int8_mode, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_sat, busy
  );
endinterface

// File: rtl/mac_acc_cla_nbit.sv
// n-bit carry-lookahead adder (generate/propagate form) shared across the multiplier datapath.
module cla_nbit #(
  parameter int unsigned n = 40
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);
  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < n; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[n-1:0];
    cout = c[n];
  end
endmodule

// File: rtl/mac_acc.sv
// Saturating dot-product accumulator: sums len products per job, then holds the result until accepted.
module mac_acc import mac_pkg::*; #(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mac_acc_if.slave  bus
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             int8_q, int8_d;
  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             take_start;

  always_comb begin
    operand = int8_q ? ACC_W'(bus.in_prod[INT8_PROD_W-1:0]) : ACC_W'(bus.in_prod);
  end

  cla_nbit #(.n(ACC_W)) u_add (
    .a    (acc_q),
    .b    (operand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A start accepted in HOLD (with out_ready) reuses the IDLE start action, so jobs run back-to-back.
  always_comb begin
    take_start = bus.start && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    int8_d  = int8_q;
    unique case (state_q)
      IDLE: ;
      ACC: begin
        if (bus.in_valid) begin
          if (add_cout) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = add_sum;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) state_d = HOLD;
        end
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take_start) begin
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      len_d   = bus.len;
      int8_d  = bus.int8_mode;
      state_d = (bus.len != '0) ? ACC : HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      int8_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      int8_q  <= int8_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == ACC);
    bus.out_valid = (state_q == HOLD);
    bus.busy      = (state_q != IDLE);
    bus.out_sum   = acc_q;
    bus.out_sat   = sat_q;
  end
endmodule

// File: tb/tb_mac_acc.sv
// Directed bench for mac_acc: vector table of whole jobs plus hand-written multi-cycle sequences.
module tb_mac_acc;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_acc_if #(.ACC_W(40), .CNT_W(8)) if40 ();
  mac_acc_if #(.ACC_W(33), .CNT_W(8)) if33 ();

  mac_acc #(.ACC_W(40), .CNT_W(8)) dut40 (.clk(clk), .rst_n(rst_n), .bus(if40.slave));
  mac_acc #(.ACC_W(33), .CNT_W(8)) dut33 (.clk(clk), .rst_n(rst_n), .bus(if33.slave));

  typedef struct {
    string        name;
    logic         int8;
    int           len;
    logic [31:0]  prod [4];
    logic [39:0]  exp_sum;
    logic         exp_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic int8, input int len,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input logic [39:0] s, input logic sat);
    vec_t v;
    v.name = name; v.int8 = int8; v.len = len;
    v.prod[0] = p0; v.prod[1] = p1; v.prod[2] = p2; v.prod[3] = p3;
    v.exp_sum = s; v.exp_sat = sat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    if40.start = 1'b1; if40.len = 8'(v.len); if40.int8_mode = v.int8; if40.out_ready = 1'b0;
    step();
    if40.start = 1'b0;
    check({v.name, "_in_ready"}, 64'(if40.in_ready), 64'(v.len != 0));
    for (int i = 0; i < v.len; i++) begin
      if (i == v.len - 1) check({v.name, "_early_valid"}, 64'(if40.out_valid), 64'd0);
      if40.in_valid = 1'b1; if40.in_prod = v.prod[i];
      step();
    end
    if40.in_valid = 1'b0;
    check({v.name, "_out_valid"}, 64'(if40.out_valid), 64'd1);
    check({v.name, "_out_sum"},   64'(if40.out_sum),   64'(v.exp_sum));
    check({v.name, "_out_sat"},   64'(if40.out_sat),   64'(v.exp_sat));
    if40.out_ready = 1'b1;
    step();
    if40.out_ready = 1'b0;
    check({v.name, "_idle_busy"}, 64'(if40.busy), 64'd0);
  endtask

  initial begin
    vecs[0] = mk("i16_len3",  1'b0, 3, 32'h0000_0010, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0,
                 40'h01_0001_000F, 1'b0);
    vecs[1] = mk("i8_len2",   1'b1, 2, 32'hABCD_0102, 32'h0000_FE01, 32'h0, 32'h0,
                 40'h00_0000_FF03, 1'b0);
    vecs[2] = mk("i16_len1",  1'b0, 1, 32'h1234_5678, 32'h0, 32'h0, 32'h0,
                 40'h00_1234_5678, 1'b0);
    vecs[3] = mk("i8_len4",   1'b1, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 40'h00_0003_FFFC, 1'b0);
    vecs[4] = mk("i16_len4",  1'b0, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 40'h03_FFFF_FFFC, 1'b0);
    vecs[5] = mk("len0",      1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 40'h0, 1'b0);

    rst_n = 1'b0;
    if40.start = 1'b0; if40.len = '0; if40.int8_mode = 1'b0;
    if40.in_valid = 1'b0; if40.in_prod = '0; if40.out_ready = 1'b0;
    if33.start = 1'b0; if33.len = '0; if33.int8_mode = 1'b0;
    if33.in_valid = 1'b0; if33.in_prod = '0; if33.out_ready = 1'b0;
    step(); step();
    check("rst_in_ready",  64'(if40.in_ready),  64'd0);
    check("rst_out_valid", 64'(if40.out_valid), 64'd0);
    check("rst_out_sum",   64'(if40.out_sum),   64'd0);
    check("rst_out_sat",   64'(if40.out_sat),   64'd0);
    check("rst_busy",      64'(if40.busy),      64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure in HOLD, then back-to-back start with the release.
    if40.start = 1'b1; if40.len = 8'd1; if40.int8_mode = 1'b0;
    step();
    if40.start = 1'b0; if40.in_valid = 1'b1; if40.in_prod = 32'd5;
    step();
    if40.in_prod = 32'h77;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(if40.out_valid), 64'd1);
      check("bp_out_sum",   64'(if40.out_sum),   64'd5);
      check("bp_out_sat",   64'(if40.out_sat),   64'd0);
      check("bp_in_ready",  64'(if40.in_ready),  64'd0);
      step();
    end
    if40.in_valid = 1'b0; if40.out_ready = 1'b1; if40.start = 1'b1; if40.len = 8'd1;
    step();
    if40.start = 1'b0; if40.out_ready = 1'b0;
    check("b2b_in_ready",  64'(if40.in_ready),  64'd1);
    check("b2b_out_valid", 64'(if40.out_valid), 64'd0);
    if40.in_valid = 1'b1; if40.in_prod = 32'd7;
    step();
    if40.in_valid = 1'b0;
    check("b2b_out_valid2", 64'(if40.out_valid), 64'd1);
    check("b2b_out_sum",    64'(if40.out_sum),   64'd7);
    if40.out_ready = 1'b1; step(); if40.out_ready = 1'b0;

    // in_valid bubbles mid-job: only beats with in_valid count.
    if40.start = 1'b1; if40.len = 8'd2;
    step();
    if40.start = 1'b0; if40.in_valid = 1'b1; if40.in_prod = 32'd3;
    step();
    if40.in_valid = 1'b0; if40.in_prod = 32'd100;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bub_in_ready",  64'(if40.in_ready),  64'd1);
      check("bub_out_valid", 64'(if40.out_valid), 64'd0);
    end
    if40.in_valid = 1'b1; if40.in_prod = 32'd4;
    step();
    if40.in_valid = 1'b0;
    check("bub_out_valid2", 64'(if40.out_valid), 64'd1);
    check("bub_out_sum",    64'(if40.out_sum),   64'd7);
    if40.out_ready = 1'b1; step(); if40.out_ready = 1'b0;

    // Reset mid-job discards the partial sum.
    if40.start = 1'b1; if40.len = 8'd4;
    step();
    if40.start = 1'b0; if40.in_valid = 1'b1; if40.in_prod = 32'h1000;
    step(); step();
    if40.in_valid = 1'b0; rst_n = 1'b0;
    step();
    check("mrst_in_ready",  64'(if40.in_ready),  64'd0);
    check("mrst_out_valid", 64'(if40.out_valid), 64'd0);
    check("mrst_out_sum",   64'(if40.out_sum),   64'd0);
    check("mrst_out_sat",   64'(if40.out_sat),   64'd0);
    check("mrst_busy",      64'(if40.busy),      64'd0);
    rst_n = 1'b1; if40.start = 1'b1; if40.len = 8'd1;
    step();
    if40.start = 1'b0; if40.in_valid = 1'b1; if40.in_prod = 32'd9;
    step();
    if40.in_valid = 1'b0;
    check("mrst_fresh_valid", 64'(if40.out_valid), 64'd1);
    check("mrst_fresh_sum",   64'(if40.out_sum),   64'd9);
    if40.out_ready = 1'b1; step(); if40.out_ready = 1'b0;

    // 33-bit accumulator saturates on the third all-ones product; sat clears on the next start.
    if33.start = 1'b1; if33.len = 8'd3; if33.int8_mode = 1'b0;
    step();
    if33.start = 1'b0; if33.in_valid = 1'b1; if33.in_prod = 32'hFFFF_FFFF;
    step(); step(); step();
    if33.in_valid = 1'b0;
    check("sat33_out_valid", 64'(if33.out_valid), 64'd1);
    check("sat33_out_sum",   64'(if33.out_sum),   64'h1_FFFF_FFFF);
    check("sat33_out_sat",   64'(if33.out_sat),   64'd1);
    if33.out_ready = 1'b1; if33.start = 1'b1; if33.len = 8'd1;
    step();
    if33.out_ready = 1'b0; if33.start = 1'b0; if33.in_valid = 1'b1; if33.in_prod = 32'd1;
    step();
    if33.in_valid = 1'b0;
    check("sat33_next_sum", 64'(if33.out_sum), 64'd1);
    check("sat33_next_sat", 64'(if33.out_sat), 64'd0);
    if33.out_ready = 1'b1; step(); if33.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
